wb_uart_rx_fifo: RTL
====================

Name: wb_uart_rx_fifo

Overview:
- UART receiver with a Wishbone slave register interface, for an FPGA-side peripheral on a SoC Wishbone bus.
- It is the receiving end of the SoC UART transmit line. Typical instance: fed from a host or board loopback of uart_tx, at 115200 8N1 on the 24 MHz wb_clk.
- Incoming serial bytes are oversampled 16x, checked for framing, and buffered in a FIFO. Software pops the FIFO through a memory-mapped data register.

Parameters:
- CLK_FREQ_HZ, 24000000, clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- FIFO_AW, 4, FIFO depth = 2^FIFO_AW entries of 8 bits.
- Derived, not overridable: DIV = (CLK_FREQ_HZ + 8*BAUD) / (16*BAUD), integer with rounding. The default gives 13. DIV must be >= 2.

Ports:
- clock  in  1  single clock for all logic.
- reset_n  in  1  asynchronous assert, active-low reset.
- rx_i  in  1  serial input, idle high, asynchronous to clock.
- wb_adr_i  in  2  word address within the block.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_we_i  in  1  write enable.
- wb_sel_i  in  4  byte selects. Ignored; all accesses are treated as 32-bit.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle.
- wb_ack_o  out  1  acknowledge.
- irq_o  out  1  interrupt, level.

Behaviour:
- Reset (reset_n low, asynchronous): all state is cleared.
  - wb_ack_o=0, wb_dat_o=0, irq_o=0.
  - FIFO empty; count=0; sticky flags=0; CTRL=0.
  - Receiver FSM in IDLE; synchronizer flops set to 1.
  - A reset in mid-frame discards the partial byte.
- Input sync: rx_i passes through a 2-flop synchronizer. Every rx reference below means the synchronized value.
- Baud tick: a prescaler counts 0..DIV-1 and pulses tick for one clock at DIV-1. The prescaler is free-running except that it is reset to 0 on leaving IDLE.
- Receiver FSM (sample counter sc 0..15 advances on each tick):
  - IDLE: a falling rx (1 then 0) moves to START with sc=0.
  - START: at sc=7, if rx=1 the start was a glitch, so return to IDLE. Otherwise go to DATA with sc=0 and bit index 0. Sampling points are therefore mid-bit.
  - DATA: at sc=15, shift rx into bit[idx], LSB first. After idx=7, go to STOP.
  - STOP: at sc=15, sample rx.
    - rx=0: set FERR sticky, drop the byte, go to IDLE.
    - rx=1 and FIFO not full: push the byte.
    - rx=1 and FIFO full: set OVR sticky, drop the byte.
    - In every case, return to IDLE and wait for the next falling edge.
- FIFO: circular buffer with FIFO_AW-bit pointers and a count of FIFO_AW+1 bits.
  - Push and pop in the same cycle: count is unchanged and both pointers advance.
  - The data output is always mem[rd_ptr].
  - Pointers wrap naturally at 2^FIFO_AW.
- Register map (wb_adr_i):
  - 0 RXDATA, read-only. Returns {24'b0, head byte}. A read while not empty pops one entry. A read while empty returns 0 and does not pop. Writes are ignored.
  - 1 STATUS.
    - bit0 NEMPTY, bit1 FULL, bit2 OVR, bit3 FERR.
    - bits[8+FIFO_AW:8] count. All other bits 0.
    - A write with bit2 or bit3 set clears the corresponding sticky flag.
    - If a sticky set and a clear happen in the same cycle, set wins.
  - 2 CTRL, read/write. bit0 IRQ_EN, bit1 ERR_IRQ_EN. Other bits read 0.
  - 3 reserved. Reads 0; writes are ignored.
- Wishbone timing:
  - When cyc&stb&!ack, the block registers wb_ack_o=1 for exactly one cycle. wb_dat_o is valid in that same cycle.
  - Side effects (pop, clear, CTRL write) occur on the cycle the ack is registered. There is exactly one per access.
  - Ack drops for at least one cycle between accesses, so back-to-back accesses take 2 cycles each.
  - wb_dat_o holds 0 whenever ack is low.
- irq_o (registered) = (IRQ_EN & NEMPTY) | (ERR_IRQ_EN & (OVR|FERR)).

Test Plan:
- Reset, then send 0x55 at 115200 (DIV=13, 208 clocks/bit) -> STATUS reads 0x00000101. RXDATA returns 0x55. STATUS then reads 0x0.
- Send 0xA3, 0x0F, 0xFF back-to-back with IRQ_EN=1 -> irq_o rises about 2 clocks after the first stop-bit sample. Three RXDATA reads return A3, 0F, FF. irq_o falls after the third.
- Send 17 bytes 0x00..0x10 with no reads (depth 16) -> FULL=1, count=16, OVR=1. Reads return 0x00..0x0F. Writing STATUS=0x4 clears OVR.
- Frame 0x3C with stop bit held low, ERR_IRQ_EN=1 -> FERR=1, irq_o=1, FIFO empty. Write 0x8 -> FERR=0, irq_o=0.
- Glitch: rx low for 3 clocks only -> no byte received and no flags. Then assert reset_n low mid-frame -> FSM idle and FIFO empty; the next full frame 0x81 is received correctly.
- Push coincident with an RXDATA pop while count=5 -> count stays 5, ordering is preserved, and ack is one cycle wide with no double pop.

Source files
------------

// File: rtl/wb_uart_rx_fifo.sv
// 16x-oversampled 8N1 UART receiver feeding a byte FIFO, exposed as a small
// Wishbone slave (RXDATA / STATUS / CTRL) with a level interrupt.
module wb_uart_rx_fifo #(
  parameter int CLK_FREQ_HZ = 24000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_AW     = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rx_i,
  input  logic [1:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        irq_o
);

  localparam int DIV   = (CLK_FREQ_HZ + 8 * BAUD) / (16 * BAUD);
  localparam int PW    = $clog2(DIV);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [PW-1:0]      DIV_M1  = PW'(DIV - 1);
  localparam logic [FIFO_AW:0]   CNT_MAX = (FIFO_AW + 1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic               sync1, rx, rx_prev;
  logic [PW-1:0]      presc;
  logic               tick, rx_fall, leave_idle;
  logic [1:0]         state;
  logic [3:0]         sc;
  logic [2:0]         idx;
  logic [7:0]         shreg;
  logic               stop_eval, push, pop, set_ovr, set_ferr;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               empty, full, ovr, ferr;
  logic [1:0]         ctrl;
  logic               req, wr, clr_ovr, clr_ferr;
  logic [31:0]        rdata;
  logic               unused_ok;

  assign unused_ok = ^{wb_sel_i, wb_dat_i[31:4]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1   <= 1'b1;
      rx      <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx_i;
      rx      <= sync1;
      rx_prev <= rx;
    end
  end

  assign rx_fall    = rx_prev & ~rx;
  assign leave_idle = (state == S_IDLE) & rx_fall;
  assign tick       = (presc == DIV_M1);

  // Restarting the prescaler at the start edge aligns sampling to mid-bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)        presc <= '0;
    else if (leave_idle) presc <= '0;
    else if (tick)       presc <= '0;
    else                 presc <= presc + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      sc    <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      case (state)
        S_IDLE: if (rx_fall) begin
          state <= S_START;
          sc    <= '0;
        end
        S_START: if (tick) begin
          if (sc == 4'd7) begin
            state <= rx ? S_IDLE : S_DATA;
            sc    <= '0;
            idx   <= '0;
          end else begin
            sc <= sc + 1'b1;
          end
        end
        S_DATA: if (tick) begin
          sc <= sc + 1'b1;
          if (sc == 4'd15) begin
            shreg[idx] <= rx;
            idx        <= idx + 1'b1;
            if (idx == 3'd7) state <= S_STOP;
          end
        end
        default: if (tick) begin
          sc <= sc + 1'b1;
          if (sc == 4'd15) state <= S_IDLE;
        end
      endcase
    end
  end

  assign stop_eval = (state == S_STOP) & tick & (sc == 4'd15);
  assign push      = stop_eval & rx & ~full;
  assign set_ovr   = stop_eval & rx & full;
  assign set_ferr  = stop_eval & ~rx;

  assign empty = (count == '0);
  assign full  = (count == CNT_MAX);

  assign req      = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr       = req & wb_we_i;
  assign pop      = req & ~wb_we_i & (wb_adr_i == 2'd0) & ~empty;
  assign clr_ovr  = wr & (wb_adr_i == 2'd1) & wb_dat_i[2];
  assign clr_ferr = wr & (wb_adr_i == 2'd1) & wb_dat_i[3];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (wb_adr_i)
      2'd0: if (!empty) rdata[7:0] = mem[rd_ptr];
      2'd1: begin
        rdata[0]            = ~empty;
        rdata[1]            = full;
        rdata[2]            = ovr;
        rdata[3]            = ferr;
        rdata[8+FIFO_AW:8]  = count;
      end
      2'd2:    rdata[1:0] = ctrl;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      ovr      <= 1'b0;
      ferr     <= 1'b0;
      ctrl     <= '0;
      irq_o    <= 1'b0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= req ? rdata : '0;
      ovr      <= (ovr & ~clr_ovr) | set_ovr;
      ferr     <= (ferr & ~clr_ferr) | set_ferr;
      if (wr && wb_adr_i == 2'd2) ctrl <= wb_dat_i[1:0];
      irq_o    <= (ctrl[0] & ~empty) | (ctrl[1] & (ovr | ferr));
    end
  end

endmodule
